key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key inputs.
REQ-002 Parameter DEPTH, default 8: consecutive equal samples required to accept a new level; legal range 2..32.
REQ-003 Parameter INIT_LEVEL, default 1'b1: debounced level after reset (keys idle high).
REQ-004 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 clk_flag  input  1  one-cycle sample-enable strobe from the upstream clock-enable divider.
REQ-007 key_in  input  N_KEYS  raw asynchronous key levels.
REQ-008 key_out  output  N_KEYS  debounced key levels.
REQ-009 key_press  output  N_KEYS  one-cycle pulse per key on a debounced high-to-low transition.
REQ-010 key_release  output  N_KEYS  one-cycle pulse per key on a debounced low-to-high transition.

Function
REQ-011 Each key_in bit SHALL pass through a 2-flop synchronizer clocked every cycle, independent of clk_flag.
REQ-012 Per key, a DEPTH-bit shift register SHALL shift in the synchronized level only in cycles where clk_flag=1.
REQ-013 Per key, a two-state FSM SHALL hold state STABLE_HIGH or STABLE_LOW; the state drives key_out directly.
REQ-014 STABLE_HIGH -> STABLE_LOW when the shift register, after the shift on a clk_flag cycle, is all zeros; STABLE_LOW -> STABLE_HIGH when it is all ones; otherwise hold.
REQ-015 key_out, key_press and key_release SHALL be registered and SHALL update on the rising edge that performs the completing shift, with no further delay.
REQ-016 key_press SHALL be high for exactly one cycle per STABLE_HIGH -> STABLE_LOW transition; key_release for exactly one cycle per STABLE_LOW -> STABLE_HIGH transition; both SHALL never be high together for the same key.
REQ-017 Any mismatching sample (bounce) inside the window SHALL delay acceptance until DEPTH consecutive matching samples have been shifted in.
REQ-018 With clk_flag held low, key_out SHALL hold regardless of key_in.
REQ-019 Keys SHALL be fully independent; simultaneous transitions on several keys SHALL pulse all of them in the same cycle.
REQ-020 Worst-case latency from a clean key_in edge to key_out change: 2 sync cycles plus DEPTH clk_flag strobes.

Reset
REQ-021 When sys_rst=1 at a clock edge: synchronizer flops and all shift register bits <= INIT_LEVEL, FSM <= state matching INIT_LEVEL, key_out <= {N_KEYS{INIT_LEVEL}}, key_press <= 0, key_release <= 0.
REQ-022 Reset asserted mid-window SHALL discard partial history; no press/release pulse SHALL be generated by reset itself or in the cycle after release.
REQ-023 sys_rst SHALL take priority over clk_flag.

Configuration
REQ-024 Macro KEY_DEBOUNCE_PRESS_CNT_EN: when defined, an extra output press_cnt (8 bits) SHALL increment by the number of key_press bits set each cycle (saturating arithmetic not used; wraps modulo 256) and reset to 0; when undefined, the port and counter SHALL not exist and behaviour is otherwise identical.

Structure
REQ-025 Package key_debounce_pkg SHALL hold the FSM state typedef (STABLE_LOW, STABLE_HIGH), the synchronizer depth constant (2) and the press_cnt width constant (8).
REQ-026 One sub-module debounce_cell SHALL implement synchronizer, shift register, FSM and pulses for a single key; key_debounce SHALL instantiate it N_KEYS times via a generate loop and hold the optional counter.

Verification (N_KEYS=4, DEPTH=4, INIT_LEVEL=1, clk_flag every 5th cycle)
REQ-027 Reset release with key_in=4'hF -> key_out=4'hF, key_press=0, key_release=0 for 100 cycles.
REQ-028 key_in[0] 1->0 cleanly -> key_out[0]=0 and key_press[0]=1 for one cycle on the 4th clk_flag after the synchronized edge; other bits unchanged.
REQ-029 key_in[1] toggling every 7 cycles for 60 cycles then held 0 -> no pulse during bounce; single key_press[1] after 4 stable strobes.
REQ-030 key_in=4'h0 simultaneously, then back to 4'hF -> one cycle key_press=4'hF, later one cycle key_release=4'hF.
REQ-031 sys_rst pulsed after 2 of 4 low samples on key_in[2] -> key_out[2] stays 1, no pulse; acceptance needs 4 fresh strobes.
REQ-032 With KEY_DEBOUNCE_PRESS_CNT_EN, 300 single-key presses -> press_cnt=44 (wrap at 256).

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer: per-key FSM state,
// synchronizer depth and optional press counter width.
package key_debounce_pkg;

    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } key_state_e;

    localparam int SYNC_DEPTH  = 2;
    localparam int PRESS_CNT_W = 8;

    function automatic key_state_e level_to_state(input logic level);
        return level ? STABLE_HIGH : STABLE_LOW;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key debouncer bus: sample strobe and raw keys in, debounced levels and
// press/release pulses out.
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    logic              clk_flag;
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_out;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output clk_flag, key_in,
        input  key_out, key_press, key_release
    );

    modport slave (
        input  clk_flag, key_in,
        output key_out, key_press, key_release
    );
endinterface

// File: rtl/key_debounce_cell.sv
// Single-key debouncer: 2-flop synchronizer, strobed sample window and a
// two-state FSM whose state is the debounced level.
module debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int   DEPTH      = 8,
    parameter logic INIT_LEVEL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clk_flag,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    logic [SYNC_DEPTH-1:0] sync;
    logic [DEPTH-1:0]      shift;
    logic [DEPTH-1:0]      shift_next;
    key_state_e            state;
    key_state_e            state_next;
    logic                  press_next;
    logic                  release_next;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync        <= {SYNC_DEPTH{INIT_LEVEL}};
            shift       <= {DEPTH{INIT_LEVEL}};
            state       <= level_to_state(INIT_LEVEL);
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_DEPTH-2:0], key_in};
            shift       <= shift_next;
            state       <= state_next;
            key_press   <= press_next;
            key_release <= release_next;
        end
    end

    // Decisions look at the window including this strobe's sample, so the
    // level flips on the very edge that completes the run.
    always_comb begin
        shift_next   = shift;
        state_next   = state;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (clk_flag) begin
            shift_next = {shift[DEPTH-2:0], sync[SYNC_DEPTH-1]};
            if (state == STABLE_HIGH) begin
                if (shift_next == '0) begin
                    state_next = STABLE_LOW;
                    press_next = 1'b1;
                end
            end else begin
                if (&shift_next) begin
                    state_next   = STABLE_HIGH;
                    release_next = 1'b1;
                end
            end
        end
    end

    assign key_out = (state == STABLE_HIGH);

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer top: one debounce_cell per key. Define
// KEY_DEBOUNCE_PRESS_CNT_EN to add the wrapping press_cnt output.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   N_KEYS     = 4,
    parameter int   DEPTH      = 8,
    parameter logic INIT_LEVEL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    key_debounce_if.slave bus
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
    ,
    output logic [PRESS_CNT_W-1:0] press_cnt
`endif
);

    logic [N_KEYS-1:0] key_out;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_cell
        debounce_cell #(
            .DEPTH      (DEPTH),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_cell (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .clk_flag    (bus.clk_flag),
            .key_in      (bus.key_in[k]),
            .key_out     (key_out[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k])
        );
    end

    assign bus.key_out     = key_out;
    assign bus.key_press   = key_press;
    assign bus.key_release = key_release;

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
    logic [PRESS_CNT_W-1:0] press_num;

    always_comb begin
        press_num = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            press_num = press_num + PRESS_CNT_W'(key_press[k]);
        end
    end

    // Counts the registered pulses, so it trails key_press by one edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            press_cnt <= '0;
        end else begin
            press_cnt <= press_cnt + press_num;
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (4 keys, depth 4, strobe every 5th cycle): a
// run-length reference model checked every cycle plus directed scenarios.
module tb_key_debounce;

    localparam int   NK   = 4;
    localparam int   DP   = 4;
    localparam logic INIT = 1'b1;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    bit   flagEn  = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   failures = 0;

    key_debounce_if #(.N_KEYS(NK)) bus ();

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
    logic [7:0] press_cnt;
`endif

    key_debounce #(
        .N_KEYS     (NK),
        .DEPTH      (DP),
        .INIT_LEVEL (INIT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
        ,
        .press_cnt (press_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        bus.clk_flag = 1'b0;
        bus.key_in   = {NK{1'b1}};
        forever begin
            @(negedge sys_clk);
            cyc++;
            bus.clk_flag = flagEn && (cyc % 5 == 0);
        end
    end

    // Reference model: a level is accepted once DP consecutive strobed
    // samples (raw keys delayed two edges) agree and differ from it.
    logic [NK-1:0] mLevel, mPress, mRelease;
    logic [NK-1:0] dly[$];
    logic          runVal[NK];
    int            runLen[NK];
    int            mCnt = 0;
    bit            mValid = 1'b0;

    always @(posedge sys_clk) begin
        logic [NK-1:0] sampled;
        if (sys_rst) begin
            mValid   = 1'b1;
            dly      = '{{NK{INIT}}, {NK{INIT}}};
            mLevel   = {NK{INIT}};
            mPress   = '0;
            mRelease = '0;
            mCnt     = 0;
            for (int k = 0; k < NK; k++) begin
                runVal[k] = INIT;
                runLen[k] = DP;
            end
        end else if (mValid) begin
            mCnt    = (mCnt + $countones(mPress)) % 256;
            sampled = dly.pop_front();
            dly.push_back(bus.key_in);
            mPress   = '0;
            mRelease = '0;
            if (bus.clk_flag) begin
                for (int k = 0; k < NK; k++) begin
                    if (sampled[k] == runVal[k]) begin
                        runLen[k] = (runLen[k] < DP) ? runLen[k] + 1 : DP;
                    end else begin
                        runVal[k] = sampled[k];
                        runLen[k] = 1;
                    end
                    if (runLen[k] >= DP && runVal[k] != mLevel[k]) begin
                        mLevel[k] = runVal[k];
                        if (runVal[k] == 1'b0) mPress[k] = 1'b1;
                        else                   mRelease[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    int pressTally[NK];
    int releaseTally[NK];

    initial begin
        for (int k = 0; k < NK; k++) begin
            pressTally[k]   = 0;
            releaseTally[k] = 0;
        end
        forever begin
            @(negedge sys_clk);
            if (mValid) begin
                checkOutput("model_key_out", 32'(bus.key_out), 32'(mLevel));
                checkOutput("model_key_press", 32'(bus.key_press), 32'(mPress));
                checkOutput("model_key_release", 32'(bus.key_release), 32'(mRelease));
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
                checkOutput("model_press_cnt", 32'(press_cnt), 32'(mCnt));
`endif
                for (int k = 0; k < NK; k++) begin
                    pressTally[k]   += int'(bus.key_press[k]);
                    releaseTally[k] += int'(bus.key_release[k]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [NK-1:0] keys, input int cycles);
        bus.key_in = keys;
        repeat (cycles) @(negedge sys_clk);
    endtask

    task automatic waitPulse(input bit isRelease, input logic [NK-1:0] mask,
                             input int limit, output int n,
                             output logic [NK-1:0] seen);
        logic [NK-1:0] v;
        n    = 0;
        seen = '0;
        while (n < limit) begin
            @(negedge sys_clk);
            n++;
            v = isRelease ? bus.key_release : bus.key_press;
            if ((v & mask) != '0) begin
                seen = v;
                break;
            end
        end
    endtask

    function automatic int tallySum(input bit isRelease);
        int s = 0;
        for (int k = 0; k < NK; k++) s += isRelease ? releaseTally[k] : pressTally[k];
        return s;
    endfunction

    initial begin
        int            n;
        logic [NK-1:0] seen;
        logic [NK-1:0] v;
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
        logic [7:0]    snap;
        logic [7:0]    delta;
`endif
        @(negedge sys_clk);
        sys_rst = 1'b1;
        applyStimulus(4'hF, 3);
        sys_rst = 1'b0;
        checkOutput("reset_key_out", 32'(bus.key_out), 32'hF);
        checkOutput("reset_key_press", 32'(bus.key_press), 32'h0);

        applyStimulus(4'hF, 100);
        checkOutput("idle_key_out", 32'(bus.key_out), 32'hF);
        checkOutput("idle_no_press", 32'(tallySum(1'b0)), 32'd0);
        checkOutput("idle_no_release", 32'(tallySum(1'b1)), 32'd0);

        bus.key_in = 4'hE;
        waitPulse(1'b0, 4'h1, 40, n, seen);
        checkOutput("k0_press_bits", 32'(seen), 32'h1);
        checkOutput("k0_latency_ok", 32'(n >= 18 && n <= 22), 32'd1);
        checkOutput("k0_key_out", 32'(bus.key_out), 32'hE);
        @(negedge sys_clk);
        checkOutput("k0_press_width", 32'(bus.key_press), 32'h0);

        v = 4'hE;
        for (int i = 0; i < 9; i++) begin
            v[1] = ~v[1];
            applyStimulus(v, 7);
        end
        checkOutput("k1_no_press_in_bounce", 32'(pressTally[1]), 32'd0);
        waitPulse(1'b0, 4'h2, 40, n, seen);
        checkOutput("k1_press_bits", 32'(seen), 32'h2);
        applyStimulus(4'hC, 5);
        checkOutput("k1_single_press", 32'(pressTally[1]), 32'd1);
        checkOutput("k1_no_release", 32'(releaseTally[1]), 32'd0);

        applyStimulus(4'hF, 40);
        checkOutput("restore_key_out", 32'(bus.key_out), 32'hF);

        bus.key_in = 4'h0;
        waitPulse(1'b0, 4'hF, 40, n, seen);
        checkOutput("all_press_together", 32'(seen), 32'hF);
        applyStimulus(4'h0, 30);
        bus.key_in = 4'hF;
        waitPulse(1'b1, 4'hF, 40, n, seen);
        checkOutput("all_release_together", 32'(seen), 32'hF);
        applyStimulus(4'hF, 30);

        flagEn = 1'b0;
        applyStimulus(4'hF, 2);
        applyStimulus(4'h0, 50);
        checkOutput("noflag_hold_key_out", 32'(bus.key_out), 32'hF);
        checkOutput("noflag_no_press", 32'(tallySum(1'b0)), 32'd6);
        applyStimulus(4'hF, 10);
        flagEn = 1'b1;
        applyStimulus(4'hF, 20);

        bus.key_in = 4'hB;
        repeat (12) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checkOutput("midreset_key_out", 32'(bus.key_out), 32'hF);
        checkOutput("midreset_no_press", 32'(bus.key_press), 32'h0);
        waitPulse(1'b0, 4'h4, 40, n, seen);
        checkOutput("k2_press_bits", 32'(seen), 32'h4);
        checkOutput("k2_fresh_window", 32'(n >= 18 && n <= 22), 32'd1);
        applyStimulus(4'hF, 40);

        checkOutput("tally_press_k0", 32'(pressTally[0]), 32'd2);
        checkOutput("tally_press_k1", 32'(pressTally[1]), 32'd2);
        checkOutput("tally_press_k2", 32'(pressTally[2]), 32'd2);
        checkOutput("tally_press_k3", 32'(pressTally[3]), 32'd1);
        checkOutput("tally_release_k2", 32'(releaseTally[2]), 32'd2);

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
        snap = press_cnt;
        for (int i = 0; i < 300; i++) begin
            bus.key_in = 4'hE;
            waitPulse(1'b0, 4'h1, 40, n, seen);
            bus.key_in = 4'hF;
            waitPulse(1'b1, 4'h1, 40, n, seen);
        end
        applyStimulus(4'hF, 3);
        delta = press_cnt - snap;
        checkOutput("press_cnt_wrap", 32'(delta), 32'd44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
